// File: rtl/dmi_responder_pkg.sv
// Shared types for the DMI responder: the debug-module transport types (dm) and
// the responder's FSM encoding, default parameters and address helper (uart_pkg).
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

package uart_pkg;

  localparam logic [6:0] DEF_BASE_ADDR    = 7'h04;
  localparam int         DEF_NUM_REGS     = 12;
  localparam int         DEF_RESP_LATENCY = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Compared in 8 bits so BASE+NUM may reach 128 without wrapping.
  function automatic logic addr_in_range(input logic [6:0] addr,
                                         input logic [6:0] base,
                                         input logic [7:0] num);
    return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} < ({1'b0, base} + num));
  endfunction

endpackage

// File: rtl/dmi_regbank.sv
// Bank of 32-bit registers: one synchronous write port, one combinational read
// port, synchronous active-low clear.
module dmi_regbank #(
  parameter int NUM_REGS = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [6:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [6:0]  i_raddr,
  output logic [31:0] o_rdata
);

  logic [31:0] r_mem [NUM_REGS];

  // Register storage with synchronous clear
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_mem[k] <= 32'h0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (i_we && (i_waddr == 7'(k))) begin
          r_mem[k] <= i_wdata;
        end
      end
    end
  end

  // Read mux; an index past the bank reads as zero
  always_comb begin
    o_rdata = 32'h0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (i_raddr == 7'(k)) begin
        o_rdata = r_mem[k];
      end
    end
  end

endmodule

// File: rtl/dmi_responder.sv
// DMI target: accepts one request at a time, waits RESP_LATENCY cycles, then
// performs the register access and holds the response until it is taken.
module dmi_responder
  import uart_pkg::*;
#(
  parameter logic [6:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter int         NUM_REGS     = DEF_NUM_REGS,
  parameter int         RESP_LATENCY = DEF_RESP_LATENCY
) (
  input  logic         CLK_I,
  input  logic         RST_NI,
  input  logic         DMI_REQ_VALID_I,
  output logic         DMI_REQ_READY_O,
  input  dm::dmi_req_t DMI_REQ_I,
  output logic         DMI_RESP_VALID_O,
  input  logic         DMI_RESP_READY_I,
  output dm::dmi_resp_t DMI_RESP_O,
  output logic [15:0]  XFER_COUNT_O
);

  localparam logic [3:0] LAT_LOAD   = (RESP_LATENCY > 0) ? 4'(RESP_LATENCY - 1) : 4'd0;
  localparam logic       LAT_ZERO   = (RESP_LATENCY == 0);
  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [3:0]    r_cnt;
  dm::dmi_req_t  r_req;
  dm::dmi_resp_t r_resp;
  logic [15:0]   r_xfer;

  logic          w_accept;
  logic          w_handshake;
  logic          w_enter_resp;
  dm::dmi_req_t  w_cur_req;
  logic          w_in_range;
  logic [6:0]    w_idx;
  logic          w_we;
  logic [31:0]   w_rdata;
  dm::dmi_resp_t w_resp_nxt;

  assign DMI_REQ_READY_O  = (r_state == ST_IDLE);
  assign DMI_RESP_VALID_O = (r_state == ST_RESP);
  assign DMI_RESP_O       = r_resp;
  assign XFER_COUNT_O     = r_xfer;

  assign w_accept     = DMI_REQ_VALID_I && (r_state == ST_IDLE);
  assign w_handshake  = DMI_RESP_READY_I && (r_state == ST_RESP);
  assign w_enter_resp = (w_accept && LAT_ZERO) || ((r_state == ST_ACCESS) && (r_cnt == 4'd0));

  // With zero latency the access happens on the accept edge, before capture lands.
  assign w_cur_req  = (r_state == ST_IDLE) ? DMI_REQ_I : r_req;
  assign w_in_range = addr_in_range(w_cur_req.addr, BASE_ADDR, NUM_REGS_W);
  assign w_idx      = w_cur_req.addr - BASE_ADDR;

  // Decode the op into a write strobe and the response to be registered
  always_comb begin
    w_we            = 1'b0;
    w_resp_nxt.data = 32'h0;
    w_resp_nxt.resp = dm::DTM_ERR;
    if (w_in_range) begin
      case (w_cur_req.op)
        dm::DTM_NOP: begin
          w_resp_nxt.resp = dm::DTM_SUCCESS;
        end
        dm::DTM_READ: begin
          w_resp_nxt.data = w_rdata;
          w_resp_nxt.resp = dm::DTM_SUCCESS;
        end
        dm::DTM_WRITE: begin
          w_we            = w_enter_resp;
          w_resp_nxt.data = w_cur_req.data;
          w_resp_nxt.resp = dm::DTM_SUCCESS;
        end
        default: begin
          w_resp_nxt.resp = dm::DTM_ERR;
        end
      endcase
    end else begin
      w_resp_nxt.resp = dm::DTM_ERR;
    end
  end

  // Next-state logic; the unused encoding falls back to idle
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = LAT_ZERO ? ST_RESP : ST_ACCESS;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (DMI_RESP_READY_I) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latency counter and request capture
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      r_cnt <= 4'd0;
      r_req <= '0;
    end else if (w_accept) begin
      r_cnt <= LAT_LOAD;
      r_req <= DMI_REQ_I;
    end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Response register, loaded on the edge entering ST_RESP
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      r_resp <= '0;
    end else if (w_enter_resp) begin
      r_resp <= w_resp_nxt;
    end else begin
      r_resp <= r_resp;
    end
  end

  // Saturating count of completed handshakes
  always_ff @(posedge CLK_I) begin
    if (!RST_NI) begin
      r_xfer <= 16'h0;
    end else if (w_handshake && (r_xfer != 16'hFFFF)) begin
      r_xfer <= r_xfer + 16'd1;
    end else begin
      r_xfer <= r_xfer;
    end
  end

  dmi_regbank #(
    .NUM_REGS (NUM_REGS)
  ) u_regbank (
    .i_clk   (CLK_I),
    .i_rst_n (RST_NI),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_cur_req.data),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_dmi_responder.sv
// Bench for dmi_responder: two instances (latency 2 and latency 0) driven by
// directed and random transactions, checked against an array-based model.
module tb_dmi_responder;

  localparam logic [6:0] BASE = 7'h04;
  localparam int         NUM  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req_valid  [2];
  dm::dmi_req_t  req        [2];
  logic          req_ready  [2];
  logic          resp_valid [2];
  logic          resp_ready [2];
  dm::dmi_resp_t resp       [2];
  logic [15:0]   xfer       [2];

  // Index 0: latency 2, index 1: latency 0
  dmi_responder #(.BASE_ADDR(BASE), .NUM_REGS(NUM), .RESP_LATENCY(2)) dut_lat2 (
    .CLK_I(clk), .RST_NI(rst_n),
    .DMI_REQ_VALID_I(req_valid[0]), .DMI_REQ_READY_O(req_ready[0]), .DMI_REQ_I(req[0]),
    .DMI_RESP_VALID_O(resp_valid[0]), .DMI_RESP_READY_I(resp_ready[0]), .DMI_RESP_O(resp[0]),
    .XFER_COUNT_O(xfer[0])
  );

  dmi_responder #(.BASE_ADDR(BASE), .NUM_REGS(NUM), .RESP_LATENCY(0)) dut_lat0 (
    .CLK_I(clk), .RST_NI(rst_n),
    .DMI_REQ_VALID_I(req_valid[1]), .DMI_REQ_READY_O(req_ready[1]), .DMI_REQ_I(req[1]),
    .DMI_RESP_VALID_O(resp_valid[1]), .DMI_RESP_READY_I(resp_ready[1]), .DMI_RESP_O(resp[1]),
    .XFER_COUNT_O(xfer[1])
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mem [2][NUM];
  int          cnt [2];

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0;
      for (int k = 0; k < NUM; k++) mem[d][k] = 32'h0;
    end
  endtask

  // Expected response and register update from the op/address rules
  task automatic model(input int d, input logic [6:0] a, input logic [1:0] op,
                       input logic [31:0] data, output logic [31:0] ed, output logic [1:0] er);
    int  ia;
    bit  inr;
    ia  = int'(a);
    inr = (ia >= int'(BASE)) && (ia < int'(BASE) + NUM);
    ed  = 32'h0;
    er  = dm::DTM_ERR;
    if (inr && op == 2'd0) begin
      er = dm::DTM_SUCCESS;
    end else if (inr && op == 2'd1) begin
      ed = mem[d][ia - int'(BASE)];
      er = dm::DTM_SUCCESS;
    end else if (inr && op == 2'd2) begin
      mem[d][ia - int'(BASE)] = data;
      ed = data;
      er = dm::DTM_SUCCESS;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req[d] = '0; resp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_resp", resp[d], 0);
      check("rst_xfer", xfer[d], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("post_rst_req_ready", req_ready[d], 1);
      check("post_rst_resp_valid", resp_valid[d], 0);
    end
    model_clear();
  endtask

  // One full transaction; entered and left just after a falling edge
  task automatic xfer_op(input int d, input logic [6:0] a, input logic [1:0] op,
                         input logic [31:0] data, input int hold);
    int            n;
    logic [31:0]   ed;
    logic [1:0]    er;
    dm::dmi_resp_t held;
    req[d].addr = a;
    req[d].op   = dm::dtm_op_e'(op);
    req[d].data = data;
    req_valid[d]  = 1'b1;
    resp_ready[d] = (hold == 0);
    n = 0;
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", req_ready[d], 1);
    model(d, a, op, data, ed, er);
    @(posedge clk);
    #1;
    // Junk request while busy must be ignored
    req[d].addr = 7'($urandom);
    req[d].op   = dm::dtm_op_e'(2'($urandom));
    req[d].data = $urandom;
    @(negedge clk);
    n = 0;
    while (!resp_valid[d] && n < 40) begin
      check("req_ready_busy", req_ready[d], 0);
      @(negedge clk);
      n++;
    end
    req_valid[d] = 1'b0;
    check("latency", n, lat_of(d));
    check("resp_data", resp[d].data, ed);
    check("resp_code", resp[d].resp, er);
    check("req_ready_resp", req_ready[d], 0);
    check("xfer_before", xfer[d], cnt[d]);
    held = resp[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", resp_valid[d], 1);
      check("hold_stable", resp[d], held);
      check("hold_req_ready", req_ready[d], 0);
      check("hold_xfer", xfer[d], cnt[d]);
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    if (cnt[d] < 65535) cnt[d]++;
    check("xfer_after", xfer[d], cnt[d]);
    check("idle_valid", resp_valid[d], 0);
    check("idle_req_ready", req_ready[d], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    logic [1:0] op;
    int         d;
    int         hold;

    do_reset();

    // Zero latency back-to-back: four writes then four reads
    for (int i = 0; i < 4; i++) xfer_op(1, BASE + 7'(i), 2'd2, 32'hC0DE_0000 + 32'(i * 17), 0);
    for (int i = 0; i < 4; i++) xfer_op(1, BASE + 7'(i), 2'd1, 32'h0, 0);
    check("lat0_count8", xfer[1], 16'd8);

    // Write then read at latency 2
    xfer_op(0, 7'h05, 2'd2, 32'hDEADBEEF, 0);
    xfer_op(0, 7'h05, 2'd1, 32'h0, 0);

    // Out of range, and top register untouched
    xfer_op(0, 7'h10, 2'd2, 32'h1234, 0);
    xfer_op(0, 7'h10, 2'd1, 32'h0, 0);
    xfer_op(0, 7'h0F, 2'd1, 32'h0, 0);
    xfer_op(0, 7'h03, 2'd2, 32'h55, 0);

    // Response backpressure
    xfer_op(0, 7'h06, 2'd2, 32'hA5A5_5A5A, 5);

    // NOP then reserved op
    xfer_op(0, 7'h05, 2'd0, 32'hFFFF_FFFF, 0);
    xfer_op(0, 7'h05, 2'd3, 32'hFFFF_FFFF, 0);
    xfer_op(0, 7'h05, 2'd1, 32'h0, 0);

    // Reset while in the access wait aborts the write
    req[0].addr = 7'h04; req[0].op = dm::DTM_WRITE; req[0].data = 32'hAA;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_in_access", resp_valid[0], 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check("abort_valid", resp_valid[0], 0);
    check("abort_ready", req_ready[0], 1);
    check("abort_xfer", xfer[0], 0);
    xfer_op(0, 7'h04, 2'd1, 32'h0, 0);
    check("abort_count1", xfer[0], 16'd1);

    // Random traffic on both instances
    for (int i = 0; i < 80; i++) begin
      d  = int'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      if (op == 2'd0) a = BASE + 7'($urandom_range(0, NUM - 1));
      else            a = 7'($urandom_range(0, 20));
      hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      xfer_op(d, a, op, $urandom, hold);
    end

    // Final sweep reads back every register
    for (int k = 0; k < NUM; k++) begin
      xfer_op(0, BASE + 7'(k), 2'd1, 32'h0, 0);
      xfer_op(1, BASE + 7'(k), 2'd1, 32'h0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_responder.md
DMI_RESPONDER -- requirements
Module: dmi_responder

Interface
REQ-001 The block SHALL be clocked by CLK_I, and its reset SHALL be RST_NI, synchronous and active-low; the design SHALL use one clock only.
REQ-002 Parameter BASE_ADDR, default 7'h04: address of register 0.
REQ-003 Parameter NUM_REGS, default 12: number of 32-bit registers; legal range 1..(128-BASE_ADDR).
REQ-004 Parameter RESP_LATENCY, default 2: extra cycles between request accept and response valid; legal range 0..15.
REQ-005 Ports, in order:
- CLK_I  in  1  clock.
- RST_NI  in  1  synchronous active-low reset.
- DMI_REQ_VALID_I  in  1  request valid.
- DMI_REQ_READY_O  out  1  request ready.
- DMI_REQ_I  in  $bits(dm::dmi_req_t)  request: addr, op, data.
- DMI_RESP_VALID_O  out  1  response valid.
- DMI_RESP_READY_I  in  1  response ready.
- DMI_RESP_O  out  $bits(dm::dmi_resp_t)  response: data, resp.
- XFER_COUNT_O  out  16  completed transactions, saturating.

Function
REQ-006 The block SHALL use a three-state FSM: ST_IDLE, ST_ACCESS, ST_RESP.
REQ-007 DMI_REQ_READY_O SHALL be 1 only in ST_IDLE.
REQ-008 A request SHALL be accepted on a cycle where valid and ready are both high; the block SHALL capture addr, op and data into local registers on that edge.
REQ-009 On accept, the FSM SHALL go to ST_ACCESS if RESP_LATENCY>0 and load the latency counter with RESP_LATENCY-1; otherwise it SHALL go directly to ST_RESP.
REQ-010 In ST_ACCESS, the counter SHALL decrement each cycle; the FSM SHALL move to ST_RESP on the edge where the counter equals 0.
REQ-011 Latency: for an accept edge at cycle T, DMI_RESP_VALID_O SHALL first be high in cycle T+1+RESP_LATENCY.
REQ-012 Register access SHALL be performed on the edge entering ST_RESP, and the response data/resp SHALL be registered on that same edge.
REQ-013 The address is in range when BASE_ADDR <= addr < BASE_ADDR+NUM_REGS; index = addr-BASE_ADDR, computed in 7 bits with no wrap.
REQ-014 Op handling:
- DTM_READ, in range: data = reg[index], resp = DTM_SUCCESS.
- DTM_WRITE, in range: reg[index] <= data; response data = the written value; resp = DTM_SUCCESS.
- DTM_NOP: no register change; data = 0; resp = DTM_SUCCESS.
- Out of range, or reserved op value 3: no register change; data = 0; resp = DTM_ERR.
REQ-015 In ST_RESP, DMI_RESP_VALID_O SHALL be 1 and DMI_RESP_O SHALL be held stable until DMI_RESP_READY_I is 1.
REQ-016 On the response handshake edge, the FSM SHALL return to ST_IDLE and XFER_COUNT_O SHALL increment, saturating at 16'hFFFF.
REQ-017 The earliest next accept SHALL be the cycle after the response handshake; no overlap of request and response is permitted.
REQ-018 DMI_REQ_VALID_I and DMI_REQ_I changes outside ST_IDLE SHALL be ignored.
REQ-019 An illegal FSM encoding SHALL recover to ST_IDLE.

Reset
REQ-020 While RST_NI=0 at a clock edge, the block SHALL load:
- FSM = ST_IDLE.
- all registers, the latency counter and the captured request = 0.
- XFER_COUNT_O = 0.
REQ-021 Output values during and immediately after reset SHALL be: DMI_REQ_READY_O=1, DMI_RESP_VALID_O=0, DMI_RESP_O=0.
REQ-022 Reset asserted in ST_ACCESS or ST_RESP SHALL abort the transaction: no register write, no response, no count increment.

Structure
REQ-023 The FSM state enum and the default parameter constants SHALL live in uart_pkg; dmi_req_t, dmi_resp_t, dtm_op_e and the resp codes SHALL come from dm.
REQ-024 The register bank SHALL be a single sub-module, dmi_regbank: one synchronous write port and one combinational read port, with synchronous reset to 0.

Verification
REQ-025 Write, then read (LAT=2):
- Stimulus: write addr 0x05, data 0xDEADBEEF; then read 0x05.
- Required: both resp=SUCCESS; read data = 0xDEADBEEF; each response valid exactly 3 cycles after its accept.
REQ-026 Out of range (BASE=0x04, NUM=12):
- Stimulus: write 0x10 with 0x1234; then read 0x10.
- Required: both resp=DTM_ERR, data=0; read of 0x0F still returns 0.
REQ-027 Response backpressure:
- Stimulus: hold DMI_RESP_READY_I low 5 cycles after response valid.
- Required: DMI_RESP_O stable; DMI_REQ_READY_O=0 throughout; XFER_COUNT_O increments only on the handshake.
REQ-028 LAT=0 back-to-back:
- Stimulus: 4 writes of distinct values, then 4 reads, with ready always high.
- Required: response one cycle after each accept; reads return the written values; XFER_COUNT_O=8.
REQ-029 Reset mid-access:
- Stimulus: accept write 0x04=0xAA, assert RST_NI=0 in ST_ACCESS, then release and read 0x04.
- Required: read data 0; XFER_COUNT_O=1.
REQ-030 NOP and reserved op:
- Stimulus: op=DTM_NOP, then op=3.
- Required: resp SUCCESS then DTM_ERR; both data 0; no register changes.
